// File: rtl/branch_ctrl_if.sv
// Branch-resolve / redirect bundle between the EX branch unit, fetch and the branch controller.
// Latency: none; this is wiring only.
// Backpressure: fetch stalls the redirect through stall_in; the controller holds redirect state meanwhile.
interface branch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             br_valid;
   logic             br_taken;
   logic [15:0]      br_pc;
   logic [15:0]      br_off;
   logic             stall_in;
   logic             clr_cnt;
   logic             redirect_valid;
   logic [15:0]      redirect_pc;
   logic             flush_if;
   logic             flush_id;
   logic             busy;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   // Pipeline side: drives resolved branches and stall, observes redirect/flush/statistics.
   modport master (
      output br_valid, br_taken, br_pc, br_off, stall_in, clr_cnt,
      input  redirect_valid, redirect_pc, flush_if, flush_id, busy,
             branch_cnt, mispredict_cnt
   );

   // Controller side.
   modport slave (
      input  br_valid, br_taken, br_pc, br_off, stall_in, clr_cnt,
      output redirect_valid, redirect_pc, flush_if, flush_id, busy,
             branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: static not-taken, so each taken branch redirects fetch and squashes wrong-path work.
// Latency: redirect_valid 1 cycle after the accepting edge; busy for FLUSH_CYCLES plus stalled cycles.
// Backpressure: stall_in holds REDIR (handshake pending) and freezes the FLUSH down-counter.
module branch_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic          clk,
   input  logic          rst,
   branch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REDIR = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // Remaining squash cycles after the redirect cycle itself.
   localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [3:0]       fcnt_q, fcnt_d;
   logic [15:0]      tgt_q, tgt_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
   logic             accept;

   // Only IDLE accepts branches; anything seen in REDIR/FLUSH is wrong-path.
   assign accept = (state_q == S_IDLE) && bus.br_valid;

   // Next-state logic: capture target on a taken branch, wait out the fetch handshake, then count the squash.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.br_valid && bus.br_taken) begin
               tgt_d   = bus.br_pc + bus.br_off;
               state_d = S_REDIR;
            end
         end
         S_REDIR: begin
            if (!bus.stall_in) begin
               fcnt_d  = FLUSH_LOAD;
               state_d = (FLUSH_CYCLES == 1) ? S_IDLE : S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!bus.stall_in) begin
               fcnt_d = fcnt_q - 4'd1;
               if (fcnt_q == 4'd1) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Statistics next-state: clear beats increment, increments stop at all-ones.
   always_comb begin
      br_cnt_d = br_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (bus.clr_cnt) begin
         br_cnt_d = '0;
         mp_cnt_d = '0;
      end else if (accept) begin
         if (br_cnt_q != CNT_MAX) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
         end
         if (bus.br_taken && (mp_cnt_q != CNT_MAX)) begin
            mp_cnt_d = mp_cnt_q + CNT_ONE;
         end
      end
   end

   // State and statistics registers; reset drops any in-flight redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         fcnt_q   <= 4'd0;
         tgt_q    <= 16'h0000;
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         tgt_q    <= tgt_d;
         br_cnt_q <= br_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

   // Outputs decode from registers only, so no input reaches an output combinationally.
   assign bus.redirect_valid = (state_q == S_REDIR);
   assign bus.flush_id       = (state_q == S_REDIR);
   assign bus.flush_if       = (state_q != S_IDLE);
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.redirect_pc    = tgt_q;
   assign bus.branch_cnt     = br_cnt_q;
   assign bus.mispredict_cnt = mp_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with a queue scoreboard.
// Each vector drives one cycle of inputs and queues the hand-computed outputs expected after that edge.
// A monitor pops and compares one entry per clock, independent of the driver.
module tb_branch_ctrl;

   typedef struct packed {
      logic        rv;
      logic [15:0] pc;
      logic        fi;
      logic        fd;
      logic        bz;
      logic [3:0]  bc;
      logic [3:0]  mc;
   } exp_t;

   logic clk;
   logic rst;

   branch_ctrl_if #(.CNT_W(4)) bif ();

   branch_ctrl #(
      .FLUSH_CYCLES (2),
      .CNT_W        (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   function automatic exp_t mk(input logic rv, input logic [15:0] pc,
                               input logic fi, input logic fd, input logic bz,
                               input logic [3:0] bc, input logic [3:0] mc);
      exp_t e;
      e.rv = rv; e.pc = pc; e.fi = fi; e.fd = fd; e.bz = bz; e.bc = bc; e.mc = mc;
      return e;
   endfunction

   task automatic vec(input string nm, input logic r, input logic bv, input logic bt,
                      input logic [15:0] pc, input logic [15:0] off,
                      input logic st, input logic cl, input exp_t e);
      @(negedge clk);
      rst          = r;
      bif.br_valid = bv;
      bif.br_taken = bt;
      bif.br_pc    = pc;
      bif.br_off   = off;
      bif.stall_in = st;
      bif.clr_cnt  = cl;
      exp_q.push_back(e);
      name_q.push_back(nm);
      n_vec++;
   endtask

   task automatic idle(input string nm, input exp_t e);
      vec(nm, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, e);
   endtask

   // Monitor: outputs settle after the edge; compare one queued expectation per cycle.
   initial begin
      exp_t  e;
      exp_t  a;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = mk(bif.redirect_valid, bif.redirect_pc, bif.flush_if, bif.flush_id,
                    bif.busy, bif.branch_cnt, bif.mispredict_cnt);
            if (a !== e) begin
               n_err++;
               $display("FAIL %s: got rv=%b pc=%h fi=%b fd=%b busy=%b bc=%0d mc=%0d, want rv=%b pc=%h fi=%b fd=%b busy=%b bc=%0d mc=%0d",
                        nm, a.rv, a.pc, a.fi, a.fd, a.bz, a.bc, a.mc,
                        e.rv, e.pc, e.fi, e.fd, e.bz, e.bc, e.mc);
            end
         end
      end
   end

   // Driver
   initial begin
      int sat;
      rst          = 1'b1;
      bif.br_valid = 1'b0;
      bif.br_taken = 1'b0;
      bif.br_pc    = 16'h0000;
      bif.br_off   = 16'h0000;
      bif.stall_in = 1'b0;
      bif.clr_cnt  = 1'b0;

      vec("reset0", 1, 0, 0, 16'h0000, 16'h0000, 0, 0, mk(0, 16'h0000, 0, 0, 0, 0, 0));
      vec("reset1", 1, 1, 1, 16'h1111, 16'h2222, 0, 1, mk(0, 16'h0000, 0, 0, 0, 0, 0));

      // Basic taken branch: 0x0010 + 5
      vec("t1_redir", 0, 1, 1, 16'h0010, 16'h0005, 0, 0, mk(1, 16'h0015, 1, 1, 1, 1, 1));
      idle("t1_flush",                                     mk(0, 16'h0015, 1, 0, 1, 1, 1));
      idle("t1_idle",                                      mk(0, 16'h0015, 0, 0, 0, 1, 1));

      // Target wraps modulo 2^16
      vec("wrap_redir", 0, 1, 1, 16'hFFFE, 16'h0004, 0, 0, mk(1, 16'h0002, 1, 1, 1, 2, 2));
      idle("wrap_flush",                                     mk(0, 16'h0002, 1, 0, 1, 2, 2));
      idle("wrap_idle",                                      mk(0, 16'h0002, 0, 0, 0, 2, 2));

      // Negative offset, with wrong-path pulses in REDIR and FLUSH
      vec("neg_redir",  0, 1, 1, 16'h0010, 16'hFFF0, 0, 0, mk(1, 16'h0000, 1, 1, 1, 3, 3));
      vec("wp_in_redir",0, 1, 1, 16'h1234, 16'h0001, 0, 0, mk(0, 16'h0000, 1, 0, 1, 3, 3));
      vec("wp_in_flush",0, 1, 0, 16'h1234, 16'h0001, 0, 0, mk(0, 16'h0000, 0, 0, 0, 3, 3));

      // Redirect stalled 3 cycles: redirect_valid held 4 cycles, target stable
      vec("st_redir",   0, 1, 1, 16'h0100, 16'h0020, 0, 0, mk(1, 16'h0120, 1, 1, 1, 4, 4));
      vec("st_hold1",   0, 1, 1, 16'h0000, 16'h0000, 1, 0, mk(1, 16'h0120, 1, 1, 1, 4, 4));
      vec("st_hold2",   0, 0, 0, 16'h0000, 16'h0000, 1, 0, mk(1, 16'h0120, 1, 1, 1, 4, 4));
      vec("st_hold3",   0, 1, 0, 16'h0000, 16'h0000, 1, 0, mk(1, 16'h0120, 1, 1, 1, 4, 4));
      idle("st_flush",                                       mk(0, 16'h0120, 1, 0, 1, 4, 4));
      idle("st_idle",                                        mk(0, 16'h0120, 0, 0, 0, 4, 4));

      // Stall during FLUSH freezes the down-counter
      vec("fs_redir",   0, 1, 1, 16'h0200, 16'h0002, 0, 0, mk(1, 16'h0202, 1, 1, 1, 5, 5));
      idle("fs_flush",                                       mk(0, 16'h0202, 1, 0, 1, 5, 5));
      vec("fs_stall",   0, 0, 0, 16'h0000, 16'h0000, 1, 0, mk(0, 16'h0202, 1, 0, 1, 5, 5));
      idle("fs_idle",                                        mk(0, 16'h0202, 0, 0, 0, 5, 5));

      // Five back-to-back not-taken branches, one under stall (accepted anyway)
      vec("nt1", 0, 1, 0, 16'h0A00, 16'h0010, 0, 0, mk(0, 16'h0202, 0, 0, 0, 6, 5));
      vec("nt2", 0, 1, 0, 16'h0A02, 16'h0010, 0, 0, mk(0, 16'h0202, 0, 0, 0, 7, 5));
      vec("nt3", 0, 1, 0, 16'h0A04, 16'h0010, 1, 0, mk(0, 16'h0202, 0, 0, 0, 8, 5));
      vec("nt4", 0, 1, 0, 16'h0A06, 16'h0010, 0, 0, mk(0, 16'h0202, 0, 0, 0, 9, 5));
      vec("nt5", 0, 1, 0, 16'h0A08, 16'h0010, 0, 0, mk(0, 16'h0202, 0, 0, 0, 10, 5));

      // Clear coincident with an accepted branch
      vec("clr_nt", 0, 1, 0, 16'h0B00, 16'h0000, 0, 1, mk(0, 16'h0202, 0, 0, 0, 0, 0));

      // 20 taken branches: both counters saturate at 15
      for (int i = 1; i <= 20; i++) begin
         sat = (i > 15) ? 15 : i;
         vec("sat_redir", 0, 1, 1, 16'h0300, 16'(i), 0, 0,
             mk(1, 16'h0300 + 16'(i), 1, 1, 1, 4'(sat), 4'(sat)));
         idle("sat_flush", mk(0, 16'h0300 + 16'(i), 1, 0, 1, 4'(sat), 4'(sat)));
         idle("sat_idle",  mk(0, 16'h0300 + 16'(i), 0, 0, 0, 4'(sat), 4'(sat)));
      end

      // Clear beats the increment of a taken branch; the FSM still takes the branch
      vec("clr_tk",   0, 1, 1, 16'h0400, 16'h0000, 0, 1, mk(1, 16'h0400, 1, 1, 1, 0, 0));
      idle("clr_fl",                                       mk(0, 16'h0400, 1, 0, 1, 0, 0));
      idle("clr_id",                                       mk(0, 16'h0400, 0, 0, 0, 0, 0));

      // Reset in the middle of FLUSH, then a taken branch right after
      vec("rf_redir", 0, 1, 1, 16'h0500, 16'h0001, 0, 0, mk(1, 16'h0501, 1, 1, 1, 1, 1));
      idle("rf_flush",                                     mk(0, 16'h0501, 1, 0, 1, 1, 1));
      vec("rf_rst",   1, 1, 1, 16'h0700, 16'h0007, 0, 0, mk(0, 16'h0000, 0, 0, 0, 0, 0));
      vec("rf_take",  0, 1, 1, 16'h0600, 16'h0006, 0, 0, mk(1, 16'h0606, 1, 1, 1, 1, 1));
      idle("rf_fl2",                                       mk(0, 16'h0606, 1, 0, 1, 1, 1));
      idle("rf_id2",                                       mk(0, 16'h0606, 0, 0, 0, 1, 1));

      // Reset in the middle of REDIR drops the redirect
      vec("rr_redir", 0, 1, 1, 16'h0800, 16'h0008, 1, 0, mk(1, 16'h0808, 1, 1, 1, 2, 2));
      vec("rr_rst",   1, 0, 0, 16'h0000, 16'h0000, 1, 0, mk(0, 16'h0000, 0, 0, 0, 0, 0));

      @(negedge clk);
      rst          = 1'b0;
      bif.br_valid = 1'b0;
      bif.stall_in = 1'b0;
      bif.clr_cnt  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
